// File: rtl/postprocess_sched_pkg.sv
// Shared widths, rescale latency and sequencer state encoding for the post-process path.
// Constants only; no logic or latency of its own.
package pp_pkg;
   localparam int ITER_W = 9;
   localparam int LEN_W  = 10;
   localparam int RS_LAT = 2;
   localparam int PIPE_D = 1 + RS_LAT;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/postprocess_sched_if.sv
// Job handshake, partial-sum read port, rescale control and output write port.
// Master is the sequencer; slave is the surrounding controller and datapath.
interface postprocess_sched_if;
   import pp_pkg::*;

   logic              start;
   logic [LEN_W-1:0]  len;
   logic              busy;
   logic              done;
   logic              psum_rd_en;
   logic [ITER_W-1:0] psum_rd_addr;
   logic              rs_en;
   logic [ITER_W-1:0] rs_iter_in;
   logic [ITER_W-1:0] rs_iter_out;
   logic              out_wr_en;
   logic [ITER_W-1:0] out_wr_addr;
   logic              out_wr_ready;

   modport master (
      input  start, len, rs_iter_out, out_wr_ready,
      output busy, done, psum_rd_en, psum_rd_addr, rs_en, rs_iter_in,
             out_wr_en, out_wr_addr
   );

   modport slave (
      output start, len, rs_iter_out, out_wr_ready,
      input  busy, done, psum_rd_en, psum_rd_addr, rs_en, rs_iter_in,
             out_wr_en, out_wr_addr
   );
endinterface

// File: rtl/postprocess_sched_valid_pipe.sv
// Enable-gated valid shift register (RAM stage + RS_LAT rescale stages) plus the stage-0 tag.
// Latency 1+RS_LAT on valid; everything holds while en is low.
module pp_valid_pipe
   import pp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              in_vld,
   input  logic [ITER_W-1:0] in_tag,
   output logic              out_vld,
   output logic [ITER_W-1:0] tag0
);
   logic [PIPE_D-1:0] vld;
   logic [ITER_W-1:0] tag_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld   <= '0;
         tag_q <= '0;
      end else if (en) begin
         vld   <= {vld[PIPE_D-2:0], in_vld};
         tag_q <= in_tag;
      end
   end

   assign out_vld = vld[PIPE_D-1];
   assign tag0    = tag_q;
endmodule

// File: rtl/postprocess_sched.sv
// Walks the partial-sum buffer, steps the rescale pipeline and writes results out; first write 4 cycles after start.
// A held write (out_wr_ready low) freezes reads, the valid pipe and the rescale pipeline.
module postprocess_sched
   import pp_pkg::*;
(
   input logic                 clk,
   input logic                 rst,
   postprocess_sched_if.master bus
);
   state_t           state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] rd_cnt;
   logic [LEN_W-1:0] wr_cnt;
   logic [LEN_W-1:0] wr_cnt_nxt;
   logic             v_rs2;
   logic             stall;
   logic             issue;
   logic             accept;

   assign stall      = v_rs2 & ~bus.out_wr_ready;
   assign bus.rs_en  = ~stall;
   assign issue      = (state == RUN) & ~stall & (rd_cnt < len_q);
   assign accept     = v_rs2 & bus.out_wr_ready;
   assign wr_cnt_nxt = wr_cnt + LEN_W'(accept);

   assign bus.psum_rd_en   = issue;
   assign bus.psum_rd_addr = rd_cnt[ITER_W-1:0];
   assign bus.out_wr_en    = v_rs2;
   assign bus.out_wr_addr  = bus.rs_iter_out;
   assign bus.busy         = (state != IDLE);
   assign bus.done         = (state == DONE);

   pp_valid_pipe u_pipe (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.rs_en),
      .in_vld  (issue),
      .in_tag  (bus.psum_rd_addr),
      .out_vld (v_rs2),
      .tag0    (bus.rs_iter_in)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         len_q  <= '0;
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  len_q  <= bus.len;
                  rd_cnt <= '0;
                  wr_cnt <= '0;
                  state  <= (bus.len == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               // Long jobs start writing before the last read is issued.
               wr_cnt <= wr_cnt_nxt;
               if (issue) begin
                  rd_cnt <= rd_cnt + LEN_W'(1);
                  if (rd_cnt + LEN_W'(1) == len_q)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               wr_cnt <= wr_cnt_nxt;
               if (wr_cnt_nxt == len_q)
                  state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/postprocess_sched.md
Name: postprocess_sched

Overview:
Sequencer for the post-process rescale datapath. On start it walks a 32-bit partial-sum buffer (two lanes per address) and drives the two-lane, 2-cycle rescale pipeline's enable and iteration tag. It then issues writes of the 8-bit results into the output feature buffer.
Downstream backpressure freezes the whole pipeline, so no result is lost. Sits between the conv accumulator buffer and the output feature-map RAM, under the layer controller's start/done handshake.

Parameters:
ITER_W, 9, width of iteration index / buffer address
LEN_W, 10, width of length field (max length 2^ITER_W)
RS_LAT, 2, rescale pipeline latency in cycles (fixed by datapath)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to process len entries
len  in  LEN_W  number of address entries, 0..512
busy  out  1  high while a job is active
done  out  1  one-cycle pulse at job completion
psum_rd_en  out  1  read strobe to partial-sum RAM (1-cycle read latency, dout held when rd_en low)
psum_rd_addr  out  ITER_W  read address
rs_en  out  1  enable to rescale pipeline (and its iteration registers)
rs_iter_in  out  ITER_W  tag of the data currently on psum RAM dout
rs_iter_out  in  ITER_W  tag emerging from rescale, aligned with its data_out0/1
out_wr_en  out  1  write request to output buffer
out_wr_addr  out  ITER_W  write address (= rs_iter_out)
out_wr_ready  in  1  output buffer accepts write this cycle

Behaviour:
- Reset: state IDLE, all counters 0, valid pipe 0. busy, done, psum_rd_en, out_wr_en = 0. rs_en = 1. Addresses and tags = 0.
- Reset mid-job aborts immediately with no done pulse. In-flight data is discarded.
- FSM states:
  - IDLE: start and len>0 -> RUN, latch len, clear rd_cnt/wr_cnt. start and len==0 -> DONE.
  - RUN: issue reads. When rd_cnt reaches len -> DRAIN.
  - DRAIN: wait until wr_cnt==len -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- busy = 1 in RUN, DRAIN and DONE. start is ignored when not in IDLE.
- Valid pipe: 3 stages, v_rd (RAM output), v_rs1, v_rs2 (rescale output).
- stall = v_rs2 & !out_wr_ready. rs_en = !stall.
- While stalled, no read is issued, and the valid pipe, tag register and rd_cnt hold.
- Read issue, when rs_en and state RUN and rd_cnt<len:
  - psum_rd_en=1, psum_rd_addr=rd_cnt, rd_cnt++.
  - v_rd <= issued. rs_iter_in <= psum_rd_addr, registered on rs_en.
- Write: out_wr_en = v_rs2, held during stall. out_wr_addr = rs_iter_out. A write is accepted when out_wr_en & out_wr_ready, which increments wr_cnt.
- Timing with no stalls, start sampled at cycle T:
  - first psum_rd_en at T+1
  - first out_wr_en at T+4 (1 RAM + RS_LAT)
  - last write at T+len+3
  - done at T+len+4
  - throughput 1 entry/cycle
- Counters are LEN_W wide so len=512 does not wrap. Addresses use the low ITER_W bits.
- A stall in the same cycle as the last read issue: the read is not issued and is retried after the stall.

Decomposition:
- Shared package pp_pkg:
  - ITER_W/LEN_W constants
  - RS_LAT constant (shared with the rescale wrapper)
  - state enum {IDLE, RUN, DRAIN, DONE}
- One natural sub-module: pp_valid_pipe, the enable-gated valid/tag shift register of depth 1+RS_LAT.

Test Plan:
- len=4, out_wr_ready=1 -> rd addr 0..3 at T+1..T+4; out_wr_addr 0..3 at T+4..T+7; done at T+8; busy low at T+9.
- len=0 -> no psum_rd_en or out_wr_en; done pulses at T+1.
- len=6, out_wr_ready low for 3 cycles at the first write -> rs_en low those cycles; out_wr_addr held at 0; no reads issued; all 6 addresses written exactly once in order; done delayed by 3.
- start pulsed again during RUN -> ignored; write count equals the original len.
- len=512 -> 512 writes, addresses 0..511, no wrap; done at T+516.
- rst asserted during DRAIN -> all outputs 0 next edge, no done; a new start with len=2 completes normally.
